apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Two-to-one APB arbiter sharing one downstream APB segment (e.g. the delayer/peripheral crossbar path in ysyxSoC) between two APB requesters, such as instruction fetch and load/store. It grants one requester at a time with round-robin priority, regenerates a clean SETUP/ACCESS sequence on the shared port and routes the response back only to the granted requester. An optional access-phase timeout ends a hung transfer with an error.

## Interface
Parameters:
- TIMEOUT, default 0: maximum number of ACCESS cycles without `out_pready`. 0 disables the timeout.
- CNT_W, default 16: width of the timeout counter. TIMEOUT must be < 2^CNT_W.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_paddr/m0_pprot/m0_pwrite/m0_pwdata/m0_pstrb  in  32/3/1/32/4  requester 0 request fields.
- m0_psel, m0_penable  in  1 each  requester 0 APB controls.
- m0_pready, m0_pslverr  out  1 each  requester 0 completion and error.
- m0_prdata  out  32  requester 0 read data.
- m1_*  same set as m0_*, for requester 1.
- out_paddr/out_pprot/out_pwrite/out_pwdata/out_pstrb  out  32/3/1/32/4  shared request fields.
- out_psel, out_penable  out  1 each  shared APB controls.
- out_pready, out_pslverr  in  1 each  shared completion and error.
- out_prdata  in  32  shared read data.
- timeout_err  out  1  one-cycle pulse when a transfer is aborted by timeout.

## Operation
- State machine with states IDLE, SETUP and ACCESS.
- **IDLE**
  - Samples `m0_psel` and `m1_psel`.
  - If either is high, the winner is registered into `gnt` and the next state is SETUP.
  - If both are high, the winner is the requester other than `last`. `last` resets to 1, so requester 0 wins the first tie.
  - `out_psel` = 0 and `out_penable` = 0.
- **SETUP**
  - `out_psel` = 1, `out_penable` = 0. The next state is always ACCESS.
  - The timeout counter is cleared.
- **ACCESS**
  - `out_psel` = 1, `out_penable` = 1. The counter increments each cycle.
  - If `out_pready` = 1:
    - pulse the grantee's `pready` for one cycle;
    - pass `out_prdata` and `out_pslverr` to the grantee;
    - set `last` to `gnt`;
    - next state is IDLE.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1:
    - pulse the grantee's `pready` = 1, `pslverr` = 1, `prdata` = 0;
    - pulse `timeout_err`;
    - set `last` to `gnt`;
    - next state is IDLE, and `out_psel` drops on the following cycle.
- **Request fields**: `out_paddr/pprot/pwrite/pwdata/pstrb` are combinationally muxed from the requester in `gnt` (requester 0 when IDLE). APB requires requesters to hold these stable until `pready`.
- **Non-granted requester**: `pready`, `prdata` and `pslverr` are 0. Its `psel`/`penable` may stay high indefinitely; it simply waits.
- **Protocol violation**: if the grantee drops `psel` mid-transfer, the downstream transfer still completes normally and the response is driven anyway.

## Timing
- **Reset values**: state IDLE, `gnt` = 0, `last` = 1, counter 0. All outputs are 0: `out_psel`, `out_penable`, all `mX_pready/pslverr/prdata`, `timeout_err`. The request-field outputs show requester 0's inputs.
- **Reset mid-transfer**: state returns to IDLE asynchronously. `out_psel`/`out_penable` drop immediately, and no `pready` is returned.
- **Minimum latency**: request `psel` in cycle 0 gives `out_psel` in cycle 1 (SETUP), `out_penable` in cycle 2, and grantee `pready` in cycle 2 with a zero-wait slave. Each downstream wait state adds one cycle.
- **Back-to-back**: at least one IDLE cycle separates transfers. A requester that keeps `psel` high after `pready` is re-arbitrated in that IDLE cycle.
- **Fairness**: with both requesters always requesting, grants strictly alternate.
- **Timeout**: with TIMEOUT = N, an unresponsive slave is released after exactly N ACCESS cycles. If `out_pready` and the timeout coincide in the same cycle, `out_pready` wins and the completion is normal, without error.

## Test plan
- **Single read**: m0 read, addr 0x1000_0000, zero-wait slave returning 0xDEADBEEF. Required: `m0_pready` in cycle 2 with `m0_prdata` = 0xDEADBEEF; `m1_pready` stays 0.
- **Simultaneous requests after reset**: m0 write 0x11 and m1 write 0x22 issued together. Required: m0 is served first, then m1 after one IDLE cycle. Downstream `out_pwdata` sequence is 0x11, then 0x22.
- **Fairness**: both requesters held continuously for 6 transfers. Required: grant order m0, m1, m0, m1, m0, m1.
- **Wait states**: slave inserts 3 wait states and asserts `pslverr` = 1. Required: `m1_pready` arrives in cycle 5 with `m1_pslverr` = 1. `out_psel` and `out_penable` stay stable throughout.
- **Timeout**: TIMEOUT = 8 with a slave that never asserts `pready`. Required: after 8 ACCESS cycles the grantee gets `pready` = 1, `pslverr` = 1, `prdata` = 0 and `timeout_err` pulses; the next requester is then served.
- **Reset in ACCESS**: assert `reset` while a transfer is in ACCESS. Required: `out_psel` = 0 in the same cycle, no `pready` pulse, and after release the next m0 request completes normally.

Source files
------------

// File: rtl/apb_arbiter_if.sv
// APB bus bundle shared by the arbiter's requester ports and its downstream port.
//   master : drives request fields + psel/penable, receives pready/pslverr/prdata
//   slave  : receives request fields + psel/penable, drives pready/pslverr/prdata
interface apb_arbiter_if;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    output paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_arbiter.sv
// Two-to-one APB arbiter. Round-robin grant between requesters m0/m1, a clean
// SETUP/ACCESS sequence regenerated on the shared port, and the response routed
// only to the grantee. Optional ACCESS-phase timeout aborts a hung transfer
// with pslverr and a one-cycle timeout_err pulse.
// Ports:
//   clock, reset  : clock, async active-high reset
//   m0, m1        : requester-side APB (arbiter acts as slave)
//   out           : shared downstream APB (arbiter acts as master)
//   timeout_err   : one-cycle pulse when a transfer is aborted by timeout
// Parameters:
//   TIMEOUT : max ACCESS cycles without out.pready (0 = no timeout)
//   CNT_W   : timeout counter width, TIMEOUT < 2**CNT_W
module apb_arbiter #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic          clock,
  input  logic          reset,
  apb_arbiter_if.slave  m0,
  apb_arbiter_if.slave  m1,
  apb_arbiter_if.master out,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state, state_nxt;
  logic             gnt, gnt_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done, tmo, fin, sel;
  logic             unused_penable;

  // Requester penable carries no information the arbiter needs: the
  // downstream phase is regenerated from the arbiter's own state.
  assign unused_penable = ^{m0.penable, m1.penable};

  // A real pready always beats a coincident timeout.
  assign done = (state == ACCESS) && out.pready;
  assign tmo  = TMO_EN && (state == ACCESS) && !out.pready && (cnt == TMO_LAST);
  assign fin  = done | tmo;
  // Request fields follow requester 0 while idle so the shared bus is quiet.
  assign sel  = (state == IDLE) ? 1'b0 : gnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (m0.psel || m1.psel) begin
          // Tie goes to whoever was not served last.
          gnt_nxt   = (m0.psel && m1.psel) ? ~last : m1.psel;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        cnt_nxt = cnt + 1'b1;
        if (fin) begin
          last_nxt  = gnt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out.psel    = (state != IDLE);
    out.penable = (state == ACCESS);
    out.paddr   = sel ? m1.paddr  : m0.paddr;
    out.pprot   = sel ? m1.pprot  : m0.pprot;
    out.pwrite  = sel ? m1.pwrite : m0.pwrite;
    out.pwdata  = sel ? m1.pwdata : m0.pwdata;
    out.pstrb   = sel ? m1.pstrb  : m0.pstrb;

    m0.pready   = fin & ~gnt;
    m1.pready   = fin &  gnt;
    m0.pslverr  = ~gnt & (done ? out.pslverr : tmo);
    m1.pslverr  =  gnt & (done ? out.pslverr : tmo);
    // Abort returns zero data; otherwise only the completing grantee sees prdata.
    m0.prdata   = (done & ~gnt) ? out.prdata : '0;
    m1.prdata   = (done &  gnt) ? out.prdata : '0;

    timeout_err = tmo;
  end
endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_apb_arbiter;
  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic timeout_err;

  apb_arbiter_if m0_if ();
  apb_arbiter_if m1_if ();
  apb_arbiter_if out_if ();

  apb_arbiter #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .out         (out_if),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  txn_t        tx [2];
  bit          pend [2];
  bit          last;
  int          chk_cnt, err_cnt;
  logic        obs_gnt;
  logic [31:0] obs_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic txn_t rand_tx();
    txn_t t;
    t.addr  = $urandom;
    t.prot  = 3'($urandom);
    t.wr    = 1'($urandom);
    t.wdata = $urandom;
    t.strb  = 4'($urandom);
    return t;
  endfunction

  function automatic logic rdy(input bit i);
    return i ? m1_if.pready : m0_if.pready;
  endfunction
  function automatic logic err_of(input bit i);
    return i ? m1_if.pslverr : m0_if.pslverr;
  endfunction
  function automatic logic [31:0] rd_of(input bit i);
    return i ? m1_if.prdata : m0_if.prdata;
  endfunction

  task automatic drive_req();
    m0_if.psel = pend[0]; m0_if.penable = 1'b0;
    m0_if.paddr = tx[0].addr; m0_if.pprot = tx[0].prot; m0_if.pwrite = tx[0].wr;
    m0_if.pwdata = tx[0].wdata; m0_if.pstrb = tx[0].strb;
    m1_if.psel = pend[1]; m1_if.penable = 1'b0;
    m1_if.paddr = tx[1].addr; m1_if.pprot = tx[1].prot; m1_if.pwrite = tx[1].wr;
    m1_if.pwdata = tx[1].wdata; m1_if.pstrb = tx[1].strb;
  endtask

  // One arbitration round starting in an IDLE cycle (just after a rising edge).
  // The slave answers after w wait states; anything beyond TMO-1 waits times out.
  task automatic round(input int w, input logic [31:0] rd, input logic se);
    bit win, fin_ok, fin_to;
    drive_req();
    out_if.pready = 1'b0;
    win = (pend[0] && pend[1]) ? ~last : pend[1];
    @(negedge clock);
    chk("idle_psel", out_if.psel, 0);
    chk("idle_pen", out_if.penable, 0);
    chk("idle_rdy", {m1_if.pready, m0_if.pready}, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("setup_psel", out_if.psel, 1);
    chk("setup_pen", out_if.penable, 0);
    chk("setup_addr", out_if.paddr, tx[win].addr);
    chk("setup_wdata", out_if.pwdata, tx[win].wdata);
    chk("setup_ctl", {out_if.pwrite, out_if.pprot, out_if.pstrb},
        {tx[win].wr, tx[win].prot, tx[win].strb});
    obs_wdata = out_if.pwdata;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clock); #1;
      fin_ok = (k == w + 1);
      fin_to = (k == TMO) && !fin_ok;
      out_if.pready  = fin_ok;
      out_if.prdata  = fin_ok ? rd : $urandom;
      out_if.pslverr = fin_ok ? se : 1'($urandom);
      @(negedge clock);
      chk("acc_psel", out_if.psel, 1);
      chk("acc_pen", out_if.penable, 1);
      chk("gnt_rdy", rdy(win), fin_ok | fin_to);
      chk("oth_rdy", rdy(!win), 0);
      chk("oth_resp", {err_of(!win), rd_of(!win)}, 0);
      chk("tmo_err", timeout_err, fin_to);
      if (fin_ok || fin_to) begin
        chk("gnt_slverr", err_of(win), fin_to ? 1'b1 : se);
        chk("gnt_prdata", rd_of(win), fin_to ? 32'h0 : rd);
        obs_gnt = m1_if.pready;
        break;
      end
    end
    last = win;
    pend[win] = 1'b0;
    @(posedge clock); #1;
    out_if.pready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit nxt;
    int w;
    chk_cnt = 0; err_cnt = 0; last = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    obs_gnt = 1'b0; obs_wdata = '0;
    out_if.pready = 1'b0; out_if.pslverr = 1'b0; out_if.prdata = '0;
    tx[0] = rand_tx(); tx[0].addr = 32'h1000_0000;
    tx[1] = rand_tx(); tx[1].addr = 32'h2000_0000;
    drive_req();

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_psel", out_if.psel, 0);
    chk("rst_pen", out_if.penable, 0);
    chk("rst_rdy", {m1_if.pready, m0_if.pready}, 0);
    chk("rst_resp", {m0_if.pslverr, m1_if.pslverr} | m0_if.prdata | m1_if.prdata, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_addr", out_if.paddr, 32'h1000_0000);
    @(posedge clock); #1;
    reset = 1'b0;

    // simultaneous writes after reset: m0 first, then m1
    tx[0] = rand_tx(); tx[0].wr = 1'b1; tx[0].wdata = 32'h11;
    tx[1] = rand_tx(); tx[1].wr = 1'b1; tx[1].wdata = 32'h22;
    pend[0] = 1'b1; pend[1] = 1'b1;
    round(0, $urandom, 1'b0);
    chk("sim_first_gnt", obs_gnt, 0);
    chk("sim_first_wdata", obs_wdata, 32'h11);
    round(0, $urandom, 1'b0);
    chk("sim_second_gnt", obs_gnt, 1);
    chk("sim_second_wdata", obs_wdata, 32'h22);

    // fairness: both always requesting
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 2; j++) if (!pend[j]) begin tx[j] = rand_tx(); pend[j] = 1'b1; end
      round($urandom_range(0, 2), $urandom, 1'b0);
      chk("fair_gnt", obs_gnt, i % 2);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;

    // single read, zero-wait slave
    tx[0] = rand_tx(); tx[0].addr = 32'h1000_0000; tx[0].wr = 1'b0;
    pend[0] = 1'b1;
    round(0, 32'hDEAD_BEEF, 1'b0);
    chk("read_gnt", obs_gnt, 0);

    // m1 with 3 wait states and slave error
    tx[1] = rand_tx(); pend[1] = 1'b1;
    round(3, $urandom, 1'b1);
    chk("wait_gnt", obs_gnt, 1);

    // timeout, then the other requester is served
    tx[0] = rand_tx(); tx[1] = rand_tx();
    pend[0] = 1'b1; pend[1] = 1'b1;
    round(100, $urandom, 1'b0);
    nxt = ~last;
    round(0, $urandom, 1'b0);
    chk("tmo_next_gnt", obs_gnt, nxt);

    // coincident pready and timeout: normal completion
    tx[1] = rand_tx(); pend[1] = 1'b1;
    round(TMO - 1, 32'h0BAD_F00D, 1'b0);

    // reset while in ACCESS
    tx[0] = rand_tx(); pend[0] = 1'b1;
    drive_req();
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_acc_pen", out_if.penable, 1);
    #2;
    out_if.pready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_acc_psel", out_if.psel, 0);
    chk("rst_acc_pen0", out_if.penable, 0);
    chk("rst_acc_rdy", {m1_if.pready, m0_if.pready}, 0);
    chk("rst_acc_terr", timeout_err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    out_if.pready = 1'b0;
    last = 1'b1;
    round(0, $urandom, 1'b0);
    chk("rst_after_gnt", obs_gnt, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 2; j++)
        if (!pend[j] && $urandom_range(0, 1) == 1) begin tx[j] = rand_tx(); pend[j] = 1'b1; end
      if (!pend[0] && !pend[1]) begin
        tx[it % 2] = rand_tx();
        pend[it % 2] = 1'b1;
      end
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
      round(w, $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end
endmodule
